// File: rtl/sdram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_responder_pkg
// Brief   : Shared command, error-code and mode-register types for the
//           synthesizable SDR SDRAM responder.
// Revision: 1.0
// ============================================================================
package sdram_responder_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_REFRESH,
        CMD_LOAD_MODE,
        CMD_BURST_TERMINATE
    } cmd_e;

    localparam logic [2:0] c_ERR_NONE           = 3'd0;
    localparam logic [2:0] c_ERR_ACT_OPEN       = 3'd1;
    localparam logic [2:0] c_ERR_ACCESS_CLOSED  = 3'd2;
    localparam logic [2:0] c_ERR_REFRESH_OPEN   = 3'd3;
    localparam logic [2:0] c_ERR_WRITE_UNDRIVEN = 3'd4;
    localparam logic [2:0] c_ERR_BAD_MODE       = 3'd5;
    localparam logic [2:0] c_ERR_CONTENTION     = 3'd6;

    // bl holds the burst length as a count (1/2/4/8), cl the CAS latency
    typedef struct packed {
        logic [3:0] bl;
        logic [1:0] cl;
        logic       single_write;
    } mode_t;

    localparam mode_t c_MODE_RESET = '{bl: 4'd1, cl: 2'd3, single_write: 1'b0};

    function automatic cmd_e decode_cmd(input logic cke, input logic csn,
                                        input logic rasn, input logic casn,
                                        input logic wen);
        cmd_e cmd;
        cmd = CMD_NOP;
        if (cke && !csn) begin
            case ({rasn, casn, wen})
                3'b011:  cmd = CMD_ACTIVE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b001:  cmd = CMD_REFRESH;
                3'b000:  cmd = CMD_LOAD_MODE;
                3'b110:  cmd = CMD_BURST_TERMINATE;
                default: cmd = CMD_NOP;
            endcase
        end
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_responder_bank_table.sv
`default_nettype none
// ============================================================================
// Module  : sdram_responder_bank_table
// Brief   : Per-bank open flag and open-row storage with lookup by bank.
// Revision: 1.0
// ============================================================================
module sdram_responder_bank_table #(
    parameter int BANK_WIDTH = 2,
    parameter int ROW_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_activate,
    input  logic                  i_precharge,
    input  logic                  i_precharge_all,
    input  logic [BANK_WIDTH-1:0] i_bank,
    input  logic [ROW_BITS-1:0]   i_row,
    output logic                  o_open,
    output logic [ROW_BITS-1:0]   o_row,
    output logic                  o_any_open
);

    localparam int c_NUM_BANKS = 1 << BANK_WIDTH;

    logic [c_NUM_BANKS-1:0] r_open;
    logic [ROW_BITS-1:0]    r_row [c_NUM_BANKS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open <= '0;
        end else if (i_activate) begin
            r_open[i_bank] <= 1'b1;
        end else if (i_precharge_all) begin
            r_open <= '0;
        end else if (i_precharge) begin
            r_open[i_bank] <= 1'b0;
        end
    end

    // Row contents only matter while the bank is open, so they need no reset
    always_ff @(posedge clk) begin
        if (i_activate) begin
            r_row[i_bank] <= i_row;
        end
    end

    assign o_open     = r_open[i_bank];
    assign o_row      = r_row[i_bank];
    assign o_any_open = |r_open;

endmodule
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module  : sdram_responder
// Brief   : Synthesizable SDR SDRAM target: command decode, bank tracking,
//           burst read/write into internal memory, sticky protocol errors.
// Revision: 1.0
// ============================================================================
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_BITS   = 2,
    parameter int COL_BITS   = 8,
    parameter int MEM_DEPTH  = 2 ** (BANK_WIDTH + ROW_BITS + COL_BITS)
) (
    input  logic                    io_axiClk,
    input  logic                    io_reset,
    input  logic [ADDR_WIDTH-1:0]   io_sdram_ADDR,
    input  logic [BANK_WIDTH-1:0]   io_sdram_BA,
    input  logic                    io_sdram_CSn,
    input  logic                    io_sdram_RASn,
    input  logic                    io_sdram_CASn,
    input  logic                    io_sdram_WEn,
    input  logic                    io_sdram_CKE,
    input  logic [DATA_WIDTH/8-1:0] io_sdram_DQM,
    input  logic [DATA_WIDTH-1:0]   io_sdram_DQ_write,
    input  logic                    io_sdram_DQ_writeEnable,
    output logic [DATA_WIDTH-1:0]   io_sdram_DQ_read,
    output logic [DATA_WIDTH/8-1:0] io_sdram_DQ_readEnable,
    output logic                    io_error,
    output logic [2:0]              io_errorCode
);

    localparam int c_NB     = DATA_WIDTH / 8;
    localparam int c_IDX_W  = BANK_WIDTH + ROW_BITS + COL_BITS;
    localparam int c_CL_MAX = 3;

    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] idx;
    } beat_t;

    function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] base,
                                                      input logic [3:0] beat,
                                                      input logic [3:0] bl);
        logic [COL_BITS-1:0] m;
        m = COL_BITS'(bl - 4'd1);
        return (base & ~m) | ((base + COL_BITS'(beat)) & m);
    endfunction

    cmd_e                  w_cmd;
    logic                  w_bank_open;
    logic [ROW_BITS-1:0]   w_bank_row;
    logic                  w_any_open;
    logic [COL_BITS-1:0]   w_col;
    mode_t                 r_mode;
    mode_t                 w_mode_new;
    logic                  w_mode_ok;
    logic                  w_kill;
    logic                  w_rd_start, w_rd_cont, w_wr_start, w_wr_cont;
    logic                  w_wr_do, w_wr_store;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [3:0]            w_wr_bl;
    beat_t                 w_rd_beat, w_tap;
    beat_t [c_CL_MAX-1:0]  r_pipe;
    logic                  r_rd_active, r_wr_active;
    logic [3:0]            r_rd_beat, r_rd_bl, r_wr_beat, r_wr_bl;
    logic [COL_BITS-1:0]   r_rd_base, r_wr_base;
    logic [BANK_WIDTH-1:0] r_rd_bank, r_wr_bank;
    logic [ROW_BITS-1:0]   r_rd_row, r_wr_row;
    logic [c_NB-1:0]       r_dqm_d1, r_dqm_d2;
    logic [DATA_WIDTH-1:0] w_lane_mask, w_mem_rd;
    logic [DATA_WIDTH-1:0] r_dq_read;
    logic [c_NB-1:0]       r_dq_read_en;
    logic                  r_error;
    logic [2:0]            r_error_code, w_err_code;
    logic [6:1]            w_err;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic                  w_unused;

    assign w_cmd    = decode_cmd(io_sdram_CKE, io_sdram_CSn, io_sdram_RASn,
                                 io_sdram_CASn, io_sdram_WEn);
    assign w_col    = io_sdram_ADDR[COL_BITS-1:0];
    assign w_unused = &{1'b0, io_sdram_ADDR};

    sdram_responder_bank_table #(
        .BANK_WIDTH (BANK_WIDTH),
        .ROW_BITS   (ROW_BITS)
    ) u_bank_table (
        .clk             (io_axiClk),
        .rst             (io_reset),
        .i_activate      (w_cmd == CMD_ACTIVE),
        .i_precharge     (w_cmd == CMD_PRECHARGE && !io_sdram_ADDR[10]),
        .i_precharge_all (w_cmd == CMD_PRECHARGE && io_sdram_ADDR[10]),
        .i_bank          (io_sdram_BA),
        .i_row           (io_sdram_ADDR[ROW_BITS-1:0]),
        .o_open          (w_bank_open),
        .o_row           (w_bank_row),
        .o_any_open      (w_any_open)
    );

    always_comb begin
        w_mode_new.bl           = 4'd1 << io_sdram_ADDR[1:0];
        w_mode_new.cl           = io_sdram_ADDR[5:4];
        w_mode_new.single_write = io_sdram_ADDR[9];
        w_mode_ok = !io_sdram_ADDR[2] && !io_sdram_ADDR[3] &&
                    (io_sdram_ADDR[6:4] == 3'd2 || io_sdram_ADDR[6:4] == 3'd3);
    end

    // Any READ/WRITE/BURST TERMINATE ends whatever burst is in flight
    assign w_kill     = (w_cmd == CMD_READ) || (w_cmd == CMD_WRITE) ||
                        (w_cmd == CMD_BURST_TERMINATE);
    assign w_rd_start = (w_cmd == CMD_READ) && w_bank_open;
    assign w_wr_start = (w_cmd == CMD_WRITE) && w_bank_open;
    assign w_rd_cont  = r_rd_active && !w_kill;
    assign w_wr_cont  = r_wr_active && !w_kill;
    assign w_wr_bl    = r_mode.single_write ? 4'd1 : r_mode.bl;

    always_comb begin
        w_rd_beat.valid = w_rd_start || w_rd_cont;
        w_rd_beat.idx   = w_rd_start ? {io_sdram_BA, w_bank_row, w_col}
                        : {r_rd_bank, r_rd_row, burst_col(r_rd_base, r_rd_beat, r_rd_bl)};
        w_wr_do         = w_wr_start || w_wr_cont;
        w_wr_idx        = w_wr_start ? {io_sdram_BA, w_bank_row, w_col}
                        : {r_wr_bank, r_wr_row, burst_col(r_wr_base, r_wr_beat, r_wr_bl)};
        w_wr_store      = w_wr_do && io_sdram_DQ_writeEnable && !io_reset;
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            r_mode <= c_MODE_RESET;
        end else if (w_cmd == CMD_LOAD_MODE && w_mode_ok) begin
            r_mode <= w_mode_new;
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            r_rd_active <= 1'b0;
            r_rd_beat   <= '0;
            r_rd_bl     <= 4'd1;
            r_rd_base   <= '0;
            r_rd_bank   <= '0;
            r_rd_row    <= '0;
        end else if (w_rd_start) begin
            r_rd_active <= (r_mode.bl != 4'd1);
            r_rd_beat   <= 4'd1;
            r_rd_bl     <= r_mode.bl;
            r_rd_base   <= w_col;
            r_rd_bank   <= io_sdram_BA;
            r_rd_row    <= w_bank_row;
        end else if (w_rd_cont) begin
            r_rd_beat   <= r_rd_beat + 4'd1;
            r_rd_active <= (r_rd_beat + 4'd1 != r_rd_bl);
        end else begin
            r_rd_active <= 1'b0;
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            r_wr_active <= 1'b0;
            r_wr_beat   <= '0;
            r_wr_bl     <= 4'd1;
            r_wr_base   <= '0;
            r_wr_bank   <= '0;
            r_wr_row    <= '0;
        end else if (w_wr_start) begin
            r_wr_active <= (w_wr_bl != 4'd1);
            r_wr_beat   <= 4'd1;
            r_wr_bl     <= w_wr_bl;
            r_wr_base   <= w_col;
            r_wr_bank   <= io_sdram_BA;
            r_wr_row    <= w_bank_row;
        end else if (w_wr_cont) begin
            r_wr_beat   <= r_wr_beat + 4'd1;
            r_wr_active <= (r_wr_beat + 4'd1 != r_wr_bl);
        end else begin
            r_wr_active <= 1'b0;
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (w_wr_store) begin
            for (int i = 0; i < c_NB; i++) begin
                if (!io_sdram_DQM[i]) begin
                    r_mem[w_wr_idx][i*8 +: 8] <= io_sdram_DQ_write[i*8 +: 8];
                end
            end
        end
    end

    // A beat issued at edge E sits in r_pipe[CL-1] just before edge E+CL
    assign w_tap    = (r_mode.cl == 2'd2) ? r_pipe[1] : r_pipe[2];
    assign w_mem_rd = r_mem[w_tap.idx];

    for (genvar i = 0; i < c_NB; i++) begin : g_lane
        assign w_lane_mask[i*8 +: 8] = {8{~r_dqm_d2[i]}};
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            r_pipe       <= '0;
            r_dqm_d1     <= '0;
            r_dqm_d2     <= '0;
            r_dq_read    <= '0;
            r_dq_read_en <= '0;
        end else begin
            r_pipe   <= {r_pipe[c_CL_MAX-2:0], w_rd_beat};
            r_dqm_d1 <= io_sdram_DQM;
            r_dqm_d2 <= r_dqm_d1;
            if (w_tap.valid) begin
                r_dq_read_en <= ~r_dqm_d2;
                r_dq_read    <= w_mem_rd & w_lane_mask;
            end else begin
                r_dq_read_en <= '0;
                r_dq_read    <= '0;
            end
        end
    end

    always_comb begin
        w_err[c_ERR_ACT_OPEN]       = (w_cmd == CMD_ACTIVE) && w_bank_open;
        w_err[c_ERR_ACCESS_CLOSED]  = (w_cmd == CMD_READ || w_cmd == CMD_WRITE) && !w_bank_open;
        w_err[c_ERR_REFRESH_OPEN]   = (w_cmd == CMD_REFRESH) && w_any_open;
        w_err[c_ERR_WRITE_UNDRIVEN] = w_wr_do && !io_sdram_DQ_writeEnable;
        w_err[c_ERR_BAD_MODE]       = (w_cmd == CMD_LOAD_MODE) && !w_mode_ok;
        w_err[c_ERR_CONTENTION]     = io_sdram_DQ_writeEnable && (|r_dq_read_en);
        w_err_code = c_ERR_NONE;
        for (int i = 6; i >= 1; i--) begin
            if (w_err[i]) begin
                w_err_code = 3'(i);
            end
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            r_error      <= 1'b0;
            r_error_code <= c_ERR_NONE;
        end else if (!r_error && (|w_err)) begin
            r_error      <= 1'b1;
            r_error_code <= w_err_code;
        end
    end

    assign io_sdram_DQ_read       = r_dq_read;
    assign io_sdram_DQ_readEnable = r_dq_read_en;
    assign io_error               = r_error;
    assign io_errorCode           = r_error_code;

endmodule
`default_nettype wire

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable SDR SDRAM target that sits on the controller's SDRAM pin bundle in simulation and FPGA loopback benches. It replaces the vendor behavioural chip model.
- It decodes SDRAM commands and tracks the open row of each bank.
- It stores write data in a small internal memory and returns read data on the split DQ bus after the programmed CAS latency.
- It flags protocol violations through a sticky error output.

Parameters:
- DATA_WIDTH, 16, DQ width; must be a multiple of 8.
- ADDR_WIDTH, 13, ADDR width.
- BANK_WIDTH, 2, BA width.
- ROW_BITS, 2, row LSBs used for memory indexing.
- COL_BITS, 8, column LSBs used for memory indexing (column = ADDR[COL_BITS-1:0]).
- MEM_DEPTH, 2^(BANK_WIDTH+ROW_BITS+COL_BITS), internal word count.

Ports:
- io_axiClk  in  1  single clock; all inputs are sampled and all outputs are updated on the rising edge.
- io_reset  in  1  synchronous, active-high reset.
- io_sdram_ADDR  in  ADDR_WIDTH  address / mode bits.
- io_sdram_BA  in  BANK_WIDTH  bank select.
- io_sdram_CSn, io_sdram_RASn, io_sdram_CASn, io_sdram_WEn  in  1 each  command bits.
- io_sdram_CKE  in  1  clock enable.
- io_sdram_DQM  in  DATA_WIDTH/8  byte masks.
- io_sdram_DQ_write  in  DATA_WIDTH  controller-driven data.
- io_sdram_DQ_writeEnable  in  1  controller drive enable.
- io_sdram_DQ_read  out  DATA_WIDTH  responder-driven data.
- io_sdram_DQ_readEnable  out  DATA_WIDTH/8  per-byte drive enable.
- io_error  out  1  sticky protocol error.
- io_errorCode  out  3  code of the first error.

Behaviour:
- Reset values:
  - DQ_read = 0, DQ_readEnable = 0, error = 0, errorCode = 0.
  - All banks closed; no burst in flight.
  - Mode register: CL = 3, BL = 1, write burst mode = burst.
  - Memory contents are not reset.
- Reset mid-burst aborts the burst. Outputs return to their reset values on the cycle after io_reset is sampled high.
- Command decoding: a cycle is NOP when CKE = 0 or CSn = 1. Otherwise {RASn, CASn, WEn} decodes as:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE (ADDR[10] = 1 means all banks)
  - 001 REFRESH
  - 000 LOAD MODE
  - 110 BURST TERMINATE
- LOAD MODE fields:
  - ADDR[2:0] burst length: 000 = 1, 001 = 2, 010 = 4, 011 = 8; other values raise error 5.
  - ADDR[3] = 1 (interleaved) raises error 5.
  - ADDR[6:4] CAS latency: 2 or 3; other values raise error 5.
  - ADDR[9] = 1 selects single-location writes.
  - If any field is illegal, the mode register keeps its previous value.
- ACTIVE opens (bank, row). ACTIVE to an already-open bank raises error 1 and the row is replaced.
- PRECHARGE closes the target bank, or all banks. Precharging a closed bank is legal.
- REFRESH while any bank is open raises error 3.
- Memory index = {BA, openRow[ROW_BITS-1:0], col[COL_BITS-1:0]}.
- Bursts:
  - Column order is sequential and wraps within a BL-aligned block: col = base[high] concatenated with (base[low] + beat) mod BL.
  - A new READ or WRITE terminates any burst in flight, read or write.
  - BURST TERMINATE ends the current burst. For reads, no further beats are output, measured from the same CL offset.
- Read timing:
  - A READ sampled at edge T drives data at edges T+CL through T+CL+BL-1.
  - During those beats DQ_readEnable[i] = ~DQM[i] as sampled 2 cycles before that beat's edge.
  - Masked lanes drive 0.
  - A READ to a closed bank raises error 2, and no data is driven for that burst.
- Write timing:
  - A WRITE sampled at edge T captures data at edges T through T+BL-1, or at edge T only in single-location mode.
  - Byte i is written only when DQM[i] = 0 in that same cycle.
  - A beat with DQ_writeEnable = 0 raises error 4 and is not stored.
  - A WRITE to a closed bank raises error 2 and the burst is ignored.
- Bus contention: if DQ_writeEnable = 1 in a cycle where any DQ_readEnable bit is high, error 6 is raised.
- Error reporting:
  - io_error sets on the edge after the violating command or beat.
  - errorCode latches only the first error.
  - When several errors occur in one cycle, the lowest code wins.
- Simultaneous events: a new command in the last beat of a burst is accepted with no gap. Read pipeline depth is CL+BL ≤ 11 and is realized as a beat shift register.

Decomposition:
- Package sdram_responder_pkg:
  - command enum (NOP, ACTIVE, READ, WRITE, PRECHARGE, REFRESH, LOAD_MODE, BURST_TERMINATE).
  - error code constants (1 = act-open, 2 = access-closed, 3 = refresh-open, 4 = write-undriven, 5 = bad-mode, 6 = contention).
  - mode register struct {bl, cl, singleWrite}.
- One sub-module: sdram_responder_bank_table. Holds per-bank open flag and row, and provides ACTIVE/PRECHARGE update and lookup.

Test Plan:
- LOAD MODE ADDR = 0x022 (CL = 2, BL = 4); ACTIVE bank 1 row 3; WRITE col 0x10 with data 0x1111/0x2222/0x3333/0x4444; READ col 0x12 -> beats on T+2..T+5 are 0x3333, 0x4444, 0x1111, 0x2222, readEnable = 2'b11.
- CL = 3, BL = 1; WRITE 0xABCD with DQM = 2'b10 over old 0x5555 -> READ returns 0x55CD at T+3, and no beat at T+4.
- READ with BL = 8, then BURST TERMINATE at T+2 (CL = 2) -> exactly 2 beats driven, readEnable = 0 from T+4.
- READ with DQM = 2'b01 asserted 2 cycles before the 2nd beat -> that beat has readEnable = 2'b10 and low byte 0x00.
- READ to a closed bank, then ACTIVE twice to bank 0 -> error = 1, errorCode = 2 (first error kept), no data driven.
- LOAD MODE with CL = 5 -> errorCode = 5, CL stays 3. Then io_reset pulse mid-burst -> outputs 0 and error cleared next cycle.
